// File: rtl/aes128_decrypt_iter_if.sv
// aes128_decrypt_iter_if: ciphertext/key request and plaintext response
// handshakes of the iterative AES-128 inverse cipher.
interface aes128_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one round per clock.
// The job key is expanded forward to round key 10, then the inverse rounds run
// while each earlier round key is regenerated by the inverse key step.
// Optional macro AES_DEC_KEY_CACHE_EN keeps the last round-10 key so a job with
// a repeated key skips the forward expansion.

// Forward AES S-box, shared by the forward and inverse key steps.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_y = SBOX[i_a];
endmodule

module aes128_decrypt_iter #(
  parameter int NR = 10
) (
  input logic                  clk,
  input logic                  rst,
  aes128_decrypt_iter_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  if (NR != 10) begin : g_nr_check
    $error("aes128_decrypt_iter supports only NR = 10");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2[k] = xt(a[k]);
      x4[k] = xt(x2[k]);
      x8[k] = xt(x4[k]);
      m9[k] = x8[k] ^ a[k];
      mb[k] = x8[k] ^ x2[k] ^ a[k];
      md[k] = x8[k] ^ x4[k] ^ a[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // Row r of the column-major state rotates right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   r_state;
  logic [127:0] r_s;
  logic [127:0] r_rk;
  logic [3:0]   r_cnt;
  logic         r_out_valid;
  logic [127:0] r_out_data;

  // The forward step feeds w3 to SubWord, the inverse step feeds w3^w2; only
  // one of them is live in any state, so one set of S-boxes serves both.
  logic [31:0]  w_w3_sel;
  logic [31:0]  w_sub;
  logic [31:0]  w_rcon;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [127:0] w_fwd;
  logic [127:0] w_inv;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_w3_sel = (r_state == S_KEYEXP) ? r_rk[31:0] : (r_rk[31:0] ^ r_rk[63:32]);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_a (w_w3_sel[31-8*((g+1)%4) -: 8]),
      .o_y (w_sub[31-8*g -: 8])
    );
  end

  assign w_rcon = {rcon(r_cnt), 24'h000000};
  assign w_f0   = r_rk[127:96] ^ w_sub ^ w_rcon;
  assign w_f1   = r_rk[95:64] ^ w_f0;
  assign w_f2   = r_rk[63:32] ^ w_f1;
  assign w_f3   = r_rk[31:0] ^ w_f2;
  assign w_fwd  = {w_f0, w_f1, w_f2, w_f3};
  assign w_inv  = {r_rk[127:96] ^ w_sub ^ w_rcon, r_rk[95:64] ^ r_rk[127:96],
                   r_rk[63:32] ^ r_rk[95:64], r_rk[31:0] ^ r_rk[63:32]};

  assign w_ark = inv_sub_bytes(inv_shift_rows(r_s)) ^ r_rk;
  assign w_imc = inv_mix_columns(w_ark);

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_key;
  logic [127:0] r_cache_key;
  logic [127:0] r_cache_rk10;
  logic         r_cache_valid;
  logic         w_cache_hit;
  assign w_cache_hit = r_cache_valid && (bus.in_key == r_cache_key);
`endif

  // Job sequencing: accept, forward key expansion, inverse rounds, output hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every state register, the wide datapath ones included, is reset
      // so an aborted job leaves nothing behind for the next one.
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_rk        <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_key         <= '0;
      r_cache_key   <= '0;
      r_cache_rk10  <= '0;
      r_cache_valid <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value of r_s, r_rk and r_cnt.
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_s <= bus.in_data;
`ifdef AES_DEC_KEY_CACHE_EN
            r_key <= bus.in_key;
            if (w_cache_hit) begin
              r_rk    <= r_cache_rk10;
              r_cnt   <= 4'd10;
              r_state <= S_ROUND;
            end else begin
              r_rk    <= bus.in_key;
              r_cnt   <= 4'd1;
              r_state <= S_KEYEXP;
            end
`else
            r_rk    <= bus.in_key;
            r_cnt   <= 4'd1;
            r_state <= S_KEYEXP;
`endif
          end
        end
        S_KEYEXP: begin
          r_rk <= w_fwd;
          if (r_cnt == 4'd10) begin
            // r_cnt already holds 10, the index of the first inverse round.
            r_state <= S_ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
            r_cache_rk10  <= w_fwd;
            r_cache_key   <= r_key;
            r_cache_valid <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ROUND: begin
          if (r_cnt == 4'd10) begin
            r_s   <= r_s ^ r_rk;
            r_rk  <= w_inv;
            r_cnt <= r_cnt - 4'd1;
          end else if (r_cnt == 4'd0) begin
            r_s         <= w_ark;
            r_out_data  <= w_ark;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_s   <= w_imc;
            r_rk  <= w_inv;
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: randomized and known-answer bench for the iterative
// AES-128 inverse cipher, checked against a byte-level FIPS-197 model whose
// S-boxes are derived from GF(2^8) inversion plus the affine map.
module tb_aes128_decrypt_iter;
  logic clk = 1'b0;
  logic rst;

  aes128_decrypt_iter_if bus ();

  aes128_decrypt_iter #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  bit           m_cache_valid;
  logic [127:0] m_cache_key;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = b;
      isb[b] = 8'(x);
    end
  endtask

  // Textbook InvCipher: full key schedule first, then byte-array rounds.
  task automatic model_decrypt(input logic [127:0] ct, input logic [127:0] key,
                               output logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  st [16];
    logic [7:0]  tmp [16];
    logic [7:0]  a [4];
    logic [7:0]  m [4];
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) st[k] = ct[127-8*k -: 8] ^ w[40 + k/4][31-8*(k%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r + 4*((c + r) % 4)] = st[r + 4*c];
      for (int k = 0; k < 16; k++) st[k] = isb[tmp[k]] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = st[4*c + k];
          for (int r = 0; r < 4; r++) begin
            st[4*c + r] = 8'h00;
            for (int k = 0; k < 4; k++) st[4*c + r] = st[4*c + r] ^ gmul(m[(k - r + 4) % 4], a[k]);
          end
        end
      end
    end
    for (int k = 0; k < 16; k++) pt[127-8*k -: 8] = st[k];
  endtask

  // Latency counts clock edges from the accepting edge (inclusive) up to the
  // edge that raises out_valid: 1 + 10 expansion + 11 rounds, or 1 + 11 on a
  // cached key.
  function automatic int model_accept(input logic [127:0] key);
    bit hit;
    hit = CACHE_EN && m_cache_valid && (key == m_cache_key);
    if (CACHE_EN && !hit) begin
      m_cache_valid = 1'b1;
      m_cache_key   = key;
    end
    return hit ? 12 : 22;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_data", bus.out_data, 128'h0);
    rst = 1'b0;
    m_cache_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [127:0] ct, input logic [127:0] key,
                         input bit rdy_early, input int hold);
    logic [127:0] exp_pt;
    int exp_lat;
    int lat;
    int waited;
    model_decrypt(ct, key, exp_pt);
    exp_lat = model_accept(key);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    bus.in_key    = key;
    bus.out_ready = rdy_early;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("%s_accept", tag), 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    // Garbage on the request side while busy must be ignored.
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    bus.in_key  = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check($sformatf("%s_latency", tag), 128'(lat), 128'(exp_lat));
    check($sformatf("%s_plaintext", tag), bus.out_data, exp_pt);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) bus.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("%s_hold_%0d", tag, i),
            {bus.out_data[124:0], bus.out_valid, bus.in_ready, bus.out_data[127]},
            {exp_pt[124:0], 1'b1, 1'b0, exp_pt[127]});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check($sformatf("%s_out_valid_clr", tag), 128'(bus.out_valid), 128'd0);
    check($sformatf("%s_in_ready_back", tag), 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] prev_key;
    logic [127:0] exp1;
    logic [127:0] exp2;
    logic [127:0] outs [2];
    int acc_cyc [2];
    int out_cyc [2];
    int n_acc;
    int n_out;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b0;
    m_cache_valid = 1'b0;
    m_cache_key   = '0;
    build_sboxes();
    do_reset();

    // Known-answer vectors; the model must agree with the published values.
    model_decrypt(C1_CT, C1_KEY, exp1);
    check("model_c1", exp1, C1_PT);
    run_job("c1", C1_CT, C1_KEY, 1'b0, 0);
    run_job("c1_again", C1_CT, C1_KEY, 1'b0, 0);
    run_job("appb", B_CT, B_KEY, 1'b0, 0);

    // Backpressure: output held for 50 cycles, requests ignored meanwhile.
    run_job("bp", B_CT, B_KEY, 1'b0, 50);

    // Reset on the same edge as a presented job wins: nothing is accepted.
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = C1_CT;
    bus.in_key   = C1_KEY;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    m_cache_valid = 1'b0;
    check("rst_prio_in_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    check("rst_prio_idle", {126'h0, bus.in_ready, bus.out_valid}, {126'h0, 1'b1, 1'b0});

    // Reset a few cycles into the inverse rounds aborts the job silently.
    key = {$urandom, $urandom, $urandom, $urandom};
    void'(model_accept(key));
    check("midrst_pre_ready", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    bus.in_key   = key;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("midrst_busy", {126'h0, bus.in_ready, bus.out_valid}, 128'h0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst_out_data", bus.out_data, 128'h0);
    check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    rst = 1'b0;
    m_cache_valid = 1'b0;
    run_job("c1_after_rst", C1_CT, C1_KEY, 1'b0, 0);

    // Back-to-back with in_valid and out_ready held high.
    model_decrypt(C1_CT, C1_KEY, exp1);
    model_decrypt(B_CT, B_KEY, exp2);
    void'(model_accept(C1_KEY));
    void'(model_accept(B_KEY));
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = C1_CT;
    bus.in_key    = C1_KEY;
    bus.out_ready = 1'b1;
    n_acc = 0;
    n_out = 0;
    acc_cyc = '{-10, -10};
    out_cyc = '{-20, -20};
    outs    = '{128'h0, 128'h0};
    for (int cyc = 0; cyc < 120 && n_out < 2; cyc++) begin
      if (bus.in_valid && bus.in_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready && n_out < 2) begin
        outs[n_out]    = bus.out_data;
        out_cyc[n_out] = cyc;
        n_out++;
      end
      @(negedge clk);
      if (n_acc == 1) begin
        bus.in_data = B_CT;
        bus.in_key  = B_KEY;
      end else if (n_acc == 2) begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_outputs", 128'(n_out), 128'd2);
    check("b2b_first", outs[0], exp1);
    check("b2b_second", outs[1], exp2);
    check("b2b_accept_gap", 128'(acc_cyc[1] - out_cyc[0]), 128'd1);

    // Randomized jobs; keys repeat now and then to exercise any key cache.
    prev_key = B_KEY;
    for (int j = 0; j < 12; j++) begin
      key = ($urandom_range(0, 1) == 1) ? prev_key : {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      run_job($sformatf("rand%0d", j), ct, key, 1'($urandom_range(0, 1)), 0);
      prev_key = key;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
